systolic_matmul_engine: RTL
===========================

# systolic_matmul_engine

Parametrised N×N output-stationary systolic matrix multiplier: accepts two N×N operand matrices over a valid/ready handshake, skews them into an internal grid of multiply-accumulate PEs and returns the N×N product over a second valid/ready handshake. It is the generalised successor to the fixed 4×4/8-bit top level. It adds configurable size and width, signed mode, and output backpressure so results are held until the consumer takes them.

## Interface
- N, 4, matrix dimension (≥2)
- W_IN, 8, operand element width
- W_ACC, 32, accumulator / result element width (≥2·W_IN)
- SIGNED, 0, 1 = two's-complement operands and products, 0 = unsigned
- i_clk  in  1  clock, rising edge
- i_arst  in  1  reset, asynchronous, active-high
- i_a  in  N×N×W_IN  matrix A, i_a[r][k] is row r, column k
- i_b  in  N×N×W_IN  matrix B, i_b[k][c]
- i_valid  in  1  operands valid
- o_ready  out  1  engine can accept operands
- o_c  out  N×N×W_ACC  product C, o_c[r][c] = Σk A[r][k]·B[k][c]
- o_valid  out  1  o_c valid
- i_ready  in  1  consumer accepts o_c

## Operation
- FSM states: IDLE, COMPUTE, DONE. Reset state is IDLE.
- o_ready = (state == IDLE), decoded from the state register. i_valid is ignored outside IDLE.
- **Accept edge E0** (IDLE, i_valid & o_ready):
  - Load the row skew buffers: row r holds A[r][0..N-1], preceded by r zero slots.
  - Load the column skew buffers: column c holds B[0..N-1][c], preceded by c zero slots.
  - Clear all accumulators and the pipeline a/b registers.
  - Set cnt = 0 and enter COMPUTE.
- **COMPUTE**:
  - Each edge, shift every skew buffer by one element, with zero fill.
  - PE[r][c] uses a_in = PE[r][c-1].a_out (column 0: row buffer r head) and b_in = PE[r-1][c].b_out (row 0: column buffer c head).
  - Each PE computes acc += a_in·b_in and registers a_in/b_in forward.
  - cnt increments each edge.
- **Arithmetic**:
  - Product is 2·W_IN bits, sign- or zero-extended per SIGNED to W_ACC.
  - Accumulation wraps modulo 2^W_ACC, with no saturation.
- **PE enable**: PE and skew registers update only in COMPUTE (or on the accept edge). They hold their value in IDLE and DONE.
- **COMPUTE exit**: on the edge where cnt == 3N-2, register all accumulators into o_c, set o_valid = 1 and enter DONE.
- **DONE**:
  - o_c and o_valid stay stable while i_ready is low.
  - On the edge where i_ready = 1, clear o_valid and enter IDLE. o_c keeps its last value.
- **Reset** (any time, including mid-COMPUTE or DONE): state IDLE, o_valid 0, o_c 0, cnt 0, accumulators/buffers/PE registers 0. No partial result is emitted.

## Timing
- Reset values: o_valid 0, o_ready 1, o_c all zero.
- The MAC for A[r][k]·B[k][c] occurs on edge E0+1+k+r+c. The last MAC occurs on edge E0+3N-2.
- o_valid rises after edge E0+3N-1, so latency from the accept edge is 3N-1 cycles (11 for N=4, 5 for N=2).
- cnt width is clog2(3N-1).
- o_ready is low from the cycle after E0 until the cycle after the output handshake edge.
  - With i_ready held high, the minimum initiation interval is 3N+1 cycles.
- i_valid arriving while o_ready is low has no effect, and the operands are not latched.
- Output handshake and the next input cannot complete in the same cycle. The next accept happens no earlier than one cycle after returning to IDLE.

## Test plan
- **Identity**, N=4, SIGNED=0: A=I, B[k][c]=4k+c+1 -> o_c equals B; o_valid rises 11 cycles after the accept edge; o_ready low throughout.
- **Unsigned max**, N=4: all elements 255 -> every o_c element 260100 (0x3F804).
- **Signed mode**, SIGNED=1, N=4: A all 0x80 (-128), B all 0x7F (127) -> every o_c element -65024 (0xFFFF0200); with A all 0x80 and B all 0x80 -> 65536.
- **Backpressure**: hold i_ready=0 for 20 cycles after o_valid -> o_c and o_valid stable; a pulse of i_valid with new operands during that window is ignored. Then i_ready=1 -> o_valid low next cycle, o_ready high, and the new operands are accepted afterwards and produce the correct product.
- **Reset mid-compute**: assert i_arst at cycle 5 of COMPUTE -> o_valid 0, o_c 0, o_ready 1 immediately. After release, a fresh A=B=all-ones (N=4) yields every element 4.
- **Small configuration**, N=2, W_IN=4, W_ACC=10: A=[[15,15],[1,2]], B=[[15,0],[15,1]] -> o_c=[[450,15],[45,2]]; latency 5 cycles.

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: N x N output-stationary systolic matrix multiplier with valid/ready in and out
module systolic_matmul_engine #(
  parameter int N      = 4,
  parameter int W_IN   = 8,
  parameter int W_ACC  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic                               i_clk,
  input  logic                               i_arst,
  input  logic [N-1:0][N-1:0][W_IN-1:0]      i_a,
  input  logic [N-1:0][N-1:0][W_IN-1:0]      i_b,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic [N-1:0][N-1:0][W_ACC-1:0]     o_c,
  output logic                               o_valid,
  input  logic                               i_ready
);
  localparam int CW = $clog2(3*N-1);
  localparam int BW = (2*N-1)*W_IN;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic o_valid_q, o_valid_d;
  logic accept, run, fin;
  logic [N-1:0][N-1:0][W_ACC-1:0] c_q, c_d, acc_q, acc_d, prod;
  logic [N-1:0][N-1:0][W_IN-1:0] a_in, b_in, bt;
  logic [N-1:0][N-2:0][W_IN-1:0] a_q, a_d;
  logic [N-2:0][N-1:0][W_IN-1:0] b_q, b_d;
  // skew buffers: slot 0 (LSBs) is the head fed into the edge PEs
  logic [N-1:0][BW-1:0] ra_q, ra_d, ra_ld, ra_sh, cb_q, cb_d, cb_ld, cb_sh;
  genvar r, c;
  generate
    for (r = 0; r < N; r++) begin : g_r
      assign ra_ld[r] = BW'(i_a[r]) << (r*W_IN);
      assign ra_sh[r] = ra_q[r] >> W_IN;
      assign cb_ld[r] = BW'(bt[r]) << (r*W_IN);
      assign cb_sh[r] = cb_q[r] >> W_IN;
      for (c = 0; c < N; c++) begin : g_c
        logic signed [2*W_IN-1:0] ps;
        logic [2*W_IN-1:0] pu;
        assign bt[c][r] = i_b[r][c];
        if (c == 0) begin : g_al
          assign a_in[r][c] = ra_q[r][W_IN-1:0];
        end else begin : g_ai
          assign a_in[r][c] = a_q[r][c-1];
        end
        if (r == 0) begin : g_bt
          assign b_in[r][c] = cb_q[c][W_IN-1:0];
        end else begin : g_bi
          assign b_in[r][c] = b_q[r-1][c];
        end
        assign ps = (2*W_IN)'($signed(a_in[r][c])) * (2*W_IN)'($signed(b_in[r][c]));
        assign pu = (2*W_IN)'(a_in[r][c]) * (2*W_IN)'(b_in[r][c]);
        assign prod[r][c] = SIGNED ? W_ACC'(ps) : W_ACC'(pu);
      end
    end
  endgenerate
  always_comb begin
    accept = state_q == IDLE && i_valid;
    run = state_q == COMPUTE;
    fin = run && cnt_q == CW'(3*N-2);
    state_d = accept ? COMPUTE : fin ? DONE : (state_q == DONE && i_ready) ? IDLE : state_q;
    cnt_d = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    o_valid_d = fin | (o_valid_q & ~(state_q == DONE && i_ready));
    c_d = fin ? acc_q : c_q;
    ra_d = accept ? ra_ld : run ? ra_sh : ra_q;
    cb_d = accept ? cb_ld : run ? cb_sh : cb_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N-1; j++)
        a_d[i][j] = accept ? '0 : run ? a_in[i][j] : a_q[i][j];
    for (int i = 0; i < N-1; i++)
      for (int j = 0; j < N; j++)
        b_d[i][j] = accept ? '0 : run ? b_in[i][j] : b_q[i][j];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc_d[i][j] = accept ? '0 : run ? acc_q[i][j] + prod[i][j] : acc_q[i][j];
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      o_valid_q <= 1'b0;
      c_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ra_q <= '0;
      cb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      o_valid_q <= o_valid_d;
      c_q <= c_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      ra_q <= ra_d;
      cb_q <= cb_d;
    end
  end
  assign o_ready = state_q == IDLE;
  assign o_c = c_q;
  assign o_valid = o_valid_q;
endmodule
